nonce_reporter: RTL and testbench
=================================

NONCE_REPORTER -- requirements
Module: nonce_reporter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of pending golden nonces buffered; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'h55, meaning the frame header byte.
REQ-003 SHALL have port hash_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port is_golden_ticket, input, 1 bit: the miner's found flag, which stays high while the miner is halted.
REQ-006 SHALL have port golden_nonce, input, 32 bits: the nonce that produced the valid hash.
REQ-007 SHALL have port tx_data, output, 8 bits: the byte offered to the downstream UART transmitter.
REQ-008 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-009 SHALL have port tx_ready, input, 1 bit: the transmitter accepts the byte.
REQ-010 SHALL have port pending, output, log2(FIFO_DEPTH)+1 bits: the number of nonces queued, excluding the frame in flight.
REQ-011 SHALL have port overflow, output, 1 bit: sticky; a nonce was dropped.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in transmission.

Function
REQ-013 SHALL capture golden_nonce only on the rising edge of is_golden_ticket (low on the previous cycle, high on this cycle); a level held high SHALL produce exactly one capture.
REQ-014 SHALL write each capture into a FIFO of FIFO_DEPTH 32-bit entries in the capture cycle; pending SHALL update on the next cycle.
REQ-015 SHALL handle a capture into a full FIFO as follows: discard the new nonce, leave the contents unchanged, and set overflow to 1 until reset.
REQ-016 SHALL implement the FSM states IDLE, HDR, NONCE, CHK:
- IDLE: goes to HDR when the FIFO is non-empty, popping the head into a frame register.
- HDR: goes to NONCE on byte acceptance.
- NONCE: sends the nonce bytes MSB first; after the 4th accepted byte, goes to CHK if checksums are enabled, else to IDLE.
- CHK: goes to IDLE on acceptance.
REQ-017 SHALL drive tx_valid high in HDR, NONCE and CHK, and low in IDLE.
REQ-018 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-019 SHALL treat a byte as accepted only when tx_valid and tx_ready are both 1 in the same cycle.
REQ-020 SHALL drive busy = (state != IDLE).
REQ-021 SHALL start the first frame's header with tx_valid high 2 cycles after the capture edge.
REQ-022 SHALL allow a new frame to begin the cycle after the previous frame's last accepted byte: the IDLE to HDR pop takes 1 cycle, so the next frame's header is valid 2 cycles after that last byte.
REQ-023 SHALL, when a capture and a pop occur in the same cycle, perform both, leave pending unchanged, and assert no overflow, even if the FIFO was full before that cycle.
REQ-024 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and compute full/empty from a counter of width log2(FIFO_DEPTH)+1.
REQ-025 SHALL ignore tx_ready while in IDLE.

Reset
REQ-026 SHALL, on reset asserting, asynchronously clear: state to IDLE, FIFO pointers and count to 0, tx_valid 0, tx_data 8'h00, overflow 0, busy 0, pending 0, and the edge-detect register to 1.
- Because the edge-detect register resets to 1, a ticket that is already high when reset releases is not captured.
REQ-027 SHALL, on reset mid-frame, abandon the frame with no completion of remaining bytes.

Configuration
REQ-028 SHALL provide the checksum byte only when macro NONCE_REPORTER_CHECKSUM_EN is defined:
- Defined: CHK state present; the frame is 6 bytes; the checksum byte is the XOR of the 4 nonce bytes.
- Undefined: the CHK state and its logic are absent; the frame is 5 bytes.

Structure
REQ-029 SHALL place the FSM state enum, the SYNC_BYTE default and the frame-length constants in a shared package miner_pkg.
REQ-030 SHALL implement the FIFO as the sub-module nonce_fifo (parameter DEPTH, 32-bit data, push/pop/full/empty/count).

Verification
REQ-031 SHALL cover this scenario: is_golden_ticket rises with golden_nonce=32'h1234ABCD and held, tx_ready=1, checksum off -> exactly bytes 55,12,34,AB,CD, one frame.
REQ-032 SHALL cover this scenario: same as REQ-031 with NONCE_REPORTER_CHECKSUM_EN defined -> bytes 55,12,34,AB,CD,40.
REQ-033 SHALL cover this scenario: tx_ready low for 10 cycles mid-nonce -> tx_data holds 8'h34 stable with tx_valid=1, then the frame completes unchanged.
REQ-034 SHALL cover this scenario: 6 ticket edges (nonces 1..6), tx_ready=0, FIFO_DEPTH=4 -> one nonce in flight, 4 queued, the 6th dropped, overflow=1; after tx_ready=1, frames 1..5 are emitted in order.
REQ-035 SHALL cover this scenario: reset asserted during byte 3 -> tx_valid low immediately, pending=0, overflow=0; a subsequent ticket edge yields a complete fresh frame.
REQ-036 SHALL cover this scenario: ticket edge on the same cycle as a pop with the FIFO full -> pending unchanged and overflow remains 0.

Source files
------------

// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the golden-nonce reporting path:
//   - frame header default, nonce byte count and frame-length constants
//   - reporter FSM state encoding
//   - checksum helper (XOR of the four nonce bytes)
// Optional feature macro: NONCE_REPORTER_CHECKSUM_EN adds the CHK state and
// lengthens the frame from 5 to 6 bytes.
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
    localparam int         NONCE_BYTES       = 4;
    localparam int         FRAME_LEN_NO_CHK  = 1 + NONCE_BYTES;
    localparam int         FRAME_LEN_CHK     = FRAME_LEN_NO_CHK + 1;

`ifdef NONCE_REPORTER_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CHK;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_NONCE = 2'd2,
        ST_CHK   = 2'd3
    } state_t;
`else
    localparam int FRAME_LEN = FRAME_LEN_NO_CHK;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_NONCE = 2'd2
    } state_t;
`endif

    // Checksum byte appended to a frame: XOR of the four nonce bytes.
    function automatic logic [7:0] nonce_checksum(input logic [31:0] nonce);
        return nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// ---------------------------------------------------------------------------
// nonce_fifo
// Small FIFO of 32-bit golden nonces. The head entry is read combinationally
// so the reporter can pop it into its frame register in the same cycle that
// it sees the FIFO non-empty.
// Ports:
//   hash_clk   - clock (rising edge)
//   reset      - asynchronous active-high reset (pointers and count)
//   push       - write push_data; accepted when not full, or when a pop
//                happens in the same cycle
//   push_data  - nonce to write
//   pop        - remove the head entry (ignored when empty)
//   pop_data   - current head entry
//   full/empty - occupancy flags derived from count
//   count      - number of stored entries (log2(DEPTH)+1 bits)
// ---------------------------------------------------------------------------
module nonce_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    output logic [31:0]              pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          pop_ok;
    logic          push_ok;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    // A simultaneous pop frees the slot, so a push into a full FIFO is
    // still taken when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge hash_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/nonce_reporter.sv
// ---------------------------------------------------------------------------
// nonce_reporter
// Captures a golden nonce on each rising edge of is_golden_ticket, queues it
// and serialises it to a byte-wide UART transmitter as a frame:
//   SYNC_BYTE, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0]
//   (+ XOR checksum byte when NONCE_REPORTER_CHECKSUM_EN is defined)
// Ports:
//   hash_clk          - clock (rising edge)
//   reset             - asynchronous active-high reset
//   is_golden_ticket  - found flag; only its rising edge captures a nonce
//   golden_nonce      - nonce to capture
//   tx_data/tx_valid  - byte offered downstream, held while not accepted
//   tx_ready          - downstream accepts the byte when tx_valid is high
//   pending           - nonces queued, excluding the frame in flight
//   overflow          - sticky: a capture was dropped on a full queue
//   busy              - a frame is being transmitted
// ---------------------------------------------------------------------------
module nonce_reporter
    import miner_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                         hash_clk,
    input  logic                         reset,
    input  logic                         is_golden_ticket,
    input  logic [31:0]                  golden_nonce,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]  pending,
    output logic                         overflow,
    output logic                         busy
);

    localparam logic [1:0] LAST_NONCE_IDX = 2'(NONCE_BYTES - 1);

    logic        ticket_d_reg;
    logic        capture;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;

    state_t      state_reg;
    logic [31:0] frame_reg;
    logic [1:0]  byte_idx_reg;
    logic [7:0]  tx_data_reg;
    logic        tx_valid_reg;
    logic        overflow_reg;
    logic        accept;

    // Nonce bytes of the frame in flight, most significant first.
    logic [7:0]  nonce_byte [NONCE_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < NONCE_BYTES; gi++) begin : g_nonce_byte
            assign nonce_byte[gi] = frame_reg[31-8*gi -: 8];
        end
    endgenerate

    assign capture  = is_golden_ticket & ~ticket_d_reg;
    assign fifo_pop = (state_reg == ST_IDLE) & ~fifo_empty;
    assign accept   = tx_valid_reg & tx_ready;

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != ST_IDLE);

    nonce_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .hash_clk  (hash_clk),
        .reset     (reset),
        .push      (capture),
        .push_data (golden_nonce),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

    // Edge detector resets high so a ticket already asserted when reset
    // releases is not mistaken for a new find. A capture into a full queue
    // is only lost when no pop frees a slot in the same cycle.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            ticket_d_reg <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            ticket_d_reg <= is_golden_ticket;
            if (capture && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            frame_reg    <= '0;
            byte_idx_reg <= '0;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        frame_reg    <= fifo_head;
                        tx_data_reg  <= SYNC_BYTE;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        tx_data_reg  <= nonce_byte[0];
                        byte_idx_reg <= '0;
                        state_reg    <= ST_NONCE;
                    end
                end
                ST_NONCE: begin
                    if (accept) begin
                        if (byte_idx_reg == LAST_NONCE_IDX) begin
`ifdef NONCE_REPORTER_CHECKSUM_EN
                            tx_data_reg  <= nonce_checksum(frame_reg);
                            state_reg    <= ST_CHK;
`else
                            tx_valid_reg <= 1'b0;
                            state_reg    <= ST_IDLE;
`endif
                        end else begin
                            tx_data_reg  <= nonce_byte[byte_idx_reg + 2'd1];
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                        end
                    end
                end
`ifdef NONCE_REPORTER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    tx_valid_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_reporter.sv
// ---------------------------------------------------------------------------
// tb_nonce_reporter
// Directed and randomised checks of nonce_reporter. Accepted bytes are
// collected by a monitor and compared with a byte stream built from the
// captured nonces (header, nonce MSB first, optional XOR checksum).
// Honours NONCE_REPORTER_CHECKSUM_EN for the expected frame format.
// ---------------------------------------------------------------------------
module tb_nonce_reporter;

    localparam int         DEPTH = 4;
    localparam logic [7:0] SYNC  = 8'h55;
`ifdef NONCE_REPORTER_CHECKSUM_EN
    localparam int FLEN   = 6;
    localparam bit CHK_ON = 1'b1;
`else
    localparam int FLEN   = 5;
    localparam bit CHK_ON = 1'b0;
`endif

    logic                     hash_clk = 1'b0;
    logic                     reset;
    logic                     is_golden_ticket;
    logic [31:0]              golden_nonce;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [$clog2(DEPTH):0]   pending;
    logic                     overflow;
    logic                     busy;

    int         n_cmp   = 0;
    int         n_fail  = 0;
    int         chk_idx = 0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    always #5 hash_clk = ~hash_clk;

    nonce_reporter #(
        .FIFO_DEPTH       (DEPTH),
        .SYNC_BYTE        (SYNC)
    ) dut (
        .hash_clk         (hash_clk),
        .reset            (reset),
        .is_golden_ticket (is_golden_ticket),
        .golden_nonce     (golden_nonce),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .pending          (pending),
        .overflow         (overflow),
        .busy             (busy)
    );

    // Byte accepted by the downstream transmitter.
    always @(posedge hash_clk) begin
        if (!reset && tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [31:0] n);
        exp_q.push_back(SYNC);
        exp_q.push_back(n[31:24]);
        exp_q.push_back(n[23:16]);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
        if (CHK_ON) begin
            exp_q.push_back(n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_rx_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) begin
                check({tag, "_rx_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
            end
        end
        chk_idx = exp_q.size();
        $display("stream %s: %0d bytes received, %0d expected", tag, rx_q.size(), exp_q.size());
    endtask

    task automatic pulse_ticket(input logic [31:0] n);
        golden_nonce     = n;
        is_golden_ticket = 1'b1;
        tick();
        is_golden_ticket = 1'b0;
        tick();
        $display("ticket edge nonce=%h", n);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy || pending != '0) && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < 500), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_byte34(input string tag);
        int n = 0;
        while (!(tx_valid && tx_data == 8'h34) && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_find_34"}, 32'(n < 30), 32'd1);
    endtask

    initial begin
        int base;
        int captures;

        // ---- reset state; ticket high across reset release is ignored
        reset            = 1'b1;
        is_golden_ticket = 1'b1;
        golden_nonce     = 32'hDEADBEEF;
        tx_ready         = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'h00);
        check("rst_pending",  32'(pending),  32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("held_ticket_busy",    32'(busy),    32'd0);
        check("held_ticket_pending", 32'(pending), 32'd0);
        is_golden_ticket = 1'b0;
        tick();

        // ---- basic frame with held ticket, latency check
        tx_ready         = 1'b1;
        golden_nonce     = 32'h1234ABCD;
        is_golden_ticket = 1'b1;
        tick();
        check("hdr_not_yet", 32'(tx_valid), 32'd0);
        tick();
        check("hdr_latency_valid", 32'(tx_valid), 32'd1);
        check("hdr_latency_data",  32'(tx_data),  32'(SYNC));
        expect_frame(32'h1234ABCD);
        repeat (20) tick();
        check("single_frame_busy",    32'(busy),    32'd0);
        check("single_frame_pending", 32'(pending), 32'd0);
        check_stream("basic");
        is_golden_ticket = 1'b0;
        tick();

        // ---- stall mid-nonce for 10 cycles
        pulse_ticket(32'h1234ABCD);
        expect_frame(32'h1234ABCD);
        wait_byte34("stall");
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data",  32'(tx_data),  32'h34);
        end
        tx_ready = 1'b1;
        drain("stall");
        check_stream("stall");

        // ---- randomised tickets and back-pressure without drops
        base     = rx_q.size();
        captures = 0;
        for (int c = 0; c < 600; c++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if (is_golden_ticket) begin
                if ($urandom_range(0, 1) == 1) is_golden_ticket = 1'b0;
            end else if ((captures - (rx_q.size() - base) / FLEN) < DEPTH &&
                         $urandom_range(0, 3) == 0) begin
                golden_nonce     = $urandom;
                is_golden_ticket = 1'b1;
                expect_frame(golden_nonce);
                captures++;
            end
            tick();
        end
        is_golden_ticket = 1'b0;
        tx_ready         = 1'b1;
        tick();
        tick();
        drain("random");
        check("random_overflow", 32'(overflow), 32'd0);
        $display("random phase: %0d captures", captures);
        check_stream("random");

        // ---- overflow: DEPTH+2 edges with transmitter stalled
        tx_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 2; i++) begin
            pulse_ticket(32'(i));
            if (i <= DEPTH + 1) expect_frame(32'(i));
        end
        tick();
        check("ovf_pending",  32'(pending),  32'(DEPTH));
        check("ovf_flag",     32'(overflow), 32'd1);
        check("ovf_busy",     32'(busy),     32'd1);
        check("ovf_tx_valid", 32'(tx_valid), 32'd1);
        check("ovf_tx_data",  32'(tx_data),  32'(SYNC));
        tx_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);
        check_stream("ovf");

        // ---- capture and pop in the same cycle with a full queue
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("rst_clears_overflow", 32'(overflow), 32'd0);
        tx_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            pulse_ticket(32'h100 + 32'(i));
            expect_frame(32'h100 + 32'(i));
        end
        tick();
        check("full_pending", 32'(pending),  32'(DEPTH));
        check("full_no_ovf",  32'(overflow), 32'd0);
        tx_ready = 1'b1;
        repeat (FLEN) tick();
        check("idle_gap_busy",    32'(busy),    32'd0);
        check("idle_gap_pending", 32'(pending), 32'(DEPTH));
        golden_nonce     = 32'hA5A5_0F0F;
        is_golden_ticket = 1'b1;
        expect_frame(32'hA5A5_0F0F);
        tick();
        is_golden_ticket = 1'b0;
        check("simul_pending",  32'(pending),  32'(DEPTH));
        check("simul_overflow", 32'(overflow), 32'd0);
        check("simul_busy",     32'(busy),     32'd1);
        tick();
        drain("simul");
        check("simul_overflow_end", 32'(overflow), 32'd0);
        check_stream("simul");

        // ---- reset during byte 3 abandons the frame
        tx_ready = 1'b1;
        pulse_ticket(32'h1234ABCD);
        wait_byte34("rstmid");
        exp_q.push_back(SYNC);
        exp_q.push_back(8'h12);
        reset = 1'b1;
        #1;
        check("rstmid_tx_valid", 32'(tx_valid), 32'd0);
        check("rstmid_pending",  32'(pending),  32'd0);
        check("rstmid_overflow", 32'(overflow), 32'd0);
        check("rstmid_busy",     32'(busy),     32'd0);
        tick();
        reset = 1'b0;
        tick();
        pulse_ticket(32'hCAFEF00D);
        expect_frame(32'hCAFEF00D);
        drain("rstmid");
        check_stream("rstmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
